// File: rtl/frame_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : frame_tx_ctrl
// Description : Frame-level transmit sequencer. Pulls frame_len words from the
//               PRBS word generator, serialises each LSB-first at a
//               programmable bit rate (one bit per speedctr+1 clocks), then
//               holds the line idle for gap_cycles clocks. Reports busy,
//               frame completion, abort and dropped-request status.
// Revision    : 1.0 - initial release
// ============================================================================
module frame_tx_ctrl #(
    parameter int WORD_W  = 10,
    parameter int SPEED_W = 4,
    parameter int LEN_W   = 8,
    parameter int GAP_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               send_req,
    input  logic               abort,
    input  logic [SPEED_W-1:0] speedctr,
    input  logic [LEN_W-1:0]   frame_len,
    input  logic [GAP_W-1:0]   gap_cycles,
    input  logic [WORD_W-1:0]  word_data,
    output logic               word_ld,
    output logic               tx_out,
    output logic               bit_tick,
    output logic               busy,
    output logic               frame_done,
    output logic               aborted,
    output logic               req_dropped
);

    localparam int                 c_BIT_W    = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(WORD_W - 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_SHIFT = 2'd1;
    localparam logic [1:0] c_ST_GAP   = 2'd2;

    logic [1:0]         r_state;
    // Bit 0 of the word lives in r_tx_out; r_shreg holds the bits still to go.
    logic [WORD_W-2:0]  r_shreg;
    logic               r_tx_out;
    logic [SPEED_W-1:0] r_spd_l;
    logic [LEN_W-1:0]   r_len_l;
    logic [GAP_W-1:0]   r_gap_l;
    logic [SPEED_W-1:0] r_div_cnt;
    logic [c_BIT_W-1:0] r_bit_cnt;
    logic [LEN_W-1:0]   r_word_cnt;
    logic [GAP_W-1:0]   r_gap_cnt;
    logic               r_frame_done;
    logic               r_aborted;
    logic               r_req_dropped;

    logic w_start;
    logic w_tick;
    logic w_last_bit;
    logic w_last_word;
    logic w_reload;

    assign w_start     = (r_state == c_ST_IDLE) && send_req && !abort && (frame_len != '0);
    assign w_tick      = (r_state == c_ST_SHIFT) && (r_div_cnt == r_spd_l);
    assign w_last_bit  = (r_bit_cnt == c_LAST_BIT);
    assign w_last_word = (r_word_cnt == (r_len_l - 1'b1));
    // Mid-frame word fetch; an abort in the same cycle cancels it.
    assign w_reload    = w_tick && w_last_bit && !w_last_word && !abort;

    assign word_ld     = rst_n && (w_start || w_reload);
    assign bit_tick    = w_tick;
    assign busy        = (r_state != c_ST_IDLE);
    assign tx_out      = r_tx_out;
    assign frame_done  = r_frame_done;
    assign aborted     = r_aborted;
    assign req_dropped = r_req_dropped;

    // Sequencer: state, counters, shift register and registered status pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= c_ST_IDLE;
            r_shreg       <= '0;
            r_tx_out      <= 1'b0;
            r_spd_l       <= '0;
            r_len_l       <= '0;
            r_gap_l       <= '0;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_word_cnt    <= '0;
            r_gap_cnt     <= '0;
            r_frame_done  <= 1'b0;
            r_aborted     <= 1'b0;
            r_req_dropped <= 1'b0;
        end else begin
            r_frame_done  <= 1'b0;
            r_aborted     <= 1'b0;
            r_req_dropped <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    r_tx_out <= 1'b0;
                    if (send_req && !abort) begin
                        if (frame_len == '0) begin
                            r_req_dropped <= 1'b1;
                        end else begin
                            r_tx_out   <= word_data[0];
                            r_shreg    <= word_data[WORD_W-1:1];
                            r_spd_l    <= speedctr;
                            r_len_l    <= frame_len;
                            r_gap_l    <= gap_cycles;
                            r_div_cnt  <= '0;
                            r_bit_cnt  <= '0;
                            r_word_cnt <= '0;
                            r_state    <= c_ST_SHIFT;
                        end
                    end
                end
                c_ST_SHIFT: begin
                    if (send_req) begin
                        r_req_dropped <= 1'b1;
                    end
                    if (abort) begin
                        r_tx_out  <= 1'b0;
                        r_aborted <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else if (w_tick) begin
                        r_div_cnt <= '0;
                        if (!w_last_bit) begin
                            r_tx_out  <= r_shreg[0];
                            r_shreg   <= r_shreg >> 1;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end else if (!w_last_word) begin
                            r_tx_out   <= word_data[0];
                            r_shreg    <= word_data[WORD_W-1:1];
                            r_bit_cnt  <= '0;
                            r_word_cnt <= r_word_cnt + 1'b1;
                        end else begin
                            r_tx_out <= 1'b0;
                            if (r_gap_l == '0) begin
                                r_frame_done <= 1'b1;
                                r_state      <= c_ST_IDLE;
                            end else begin
                                r_gap_cnt <= '0;
                                r_state   <= c_ST_GAP;
                            end
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                c_ST_GAP: begin
                    r_tx_out <= 1'b0;
                    if (send_req) begin
                        r_req_dropped <= 1'b1;
                    end
                    if (abort) begin
                        r_aborted <= 1'b1;
                        r_state   <= c_ST_IDLE;
                    end else if (r_gap_cnt == (r_gap_l - 1'b1)) begin
                        r_frame_done <= 1'b1;
                        r_state      <= c_ST_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx_out <= 1'b0;
                    r_state  <= c_ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_frame_tx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_frame_tx_ctrl
// Description : Self-checking bench for frame_tx_ctrl. Expected waveforms are
//               computed from frame timing arithmetic (word period, bit
//               period, gap length) rather than from a state machine.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_tx_ctrl;

    localparam int WORD_W  = 10;
    localparam int SPEED_W = 4;
    localparam int LEN_W   = 8;
    localparam int GAP_W   = 8;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               send_req;
    logic               abort;
    logic [SPEED_W-1:0] speedctr;
    logic [LEN_W-1:0]   frame_len;
    logic [GAP_W-1:0]   gap_cycles;
    logic [WORD_W-1:0]  word_data;
    logic               word_ld;
    logic               tx_out;
    logic               bit_tick;
    logic               busy;
    logic               frame_done;
    logic               aborted;
    logic               req_dropped;

    int n_pass  = 0;
    int n_total = 0;

    logic [WORD_W-1:0] words [256];

    typedef struct {
        logic       send_req;
        logic       abort;
        logic [7:0] frame_len;
        logic       exp_ld;
        logic       exp_busy;
        logic       exp_drop;
    } vec_t;

    vec_t vecs [6];

    frame_tx_ctrl #(
        .WORD_W  (WORD_W),
        .SPEED_W (SPEED_W),
        .LEN_W   (LEN_W),
        .GAP_W   (GAP_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .send_req    (send_req),
        .abort       (abort),
        .speedctr    (speedctr),
        .frame_len   (frame_len),
        .gap_cycles  (gap_cycles),
        .word_data   (word_data),
        .word_ld     (word_ld),
        .tx_out      (tx_out),
        .bit_tick    (bit_tick),
        .busy        (busy),
        .frame_done  (frame_done),
        .aborted     (aborted),
        .req_dropped (req_dropped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int cyc, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s cycle %0d: got %0b, expected %0b", name, cyc, act, exp);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n    = 1'b0;
        send_req = 1'b0;
        abort    = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One frame started at cycle 0; every output compared each cycle.
    // ab_at / drop_at < 0 disable the abort / extra request.
    task automatic run_frame(input int spd, input int len, input int gap,
                             input int ab_at, input int drop_at, input bit scramble);
        int p    = WORD_W * (spd + 1);
        int l    = len * p;
        int last = (ab_at >= 0) ? ab_at : l + gap;
        for (int t = 0; t <= last + 3; t++) begin
            int   k;
            int   idx;
            logic e_tx, e_tick, e_ld, e_busy, e_done, e_ab, e_drop;
            @(posedge clk); #1;
            k        = (t + p - 1) / p;
            send_req = (t == 0) || (t == drop_at);
            abort    = (t == ab_at);
            word_data = (k < len) ? words[k] : WORD_W'($urandom);
            if (t == 0 || !scramble) begin
                speedctr   = SPEED_W'(spd);
                frame_len  = LEN_W'(len);
                gap_cycles = GAP_W'(gap);
            end else begin
                speedctr   = SPEED_W'($urandom);
                frame_len  = LEN_W'($urandom);
                gap_cycles = GAP_W'($urandom);
            end
            @(negedge clk);
            e_busy = (t >= 1) && (t <= last);
            e_tx   = 1'b0;
            if (t >= 1 && t <= l && t <= last) begin
                idx  = t - 1;
                e_tx = words[idx / p][(idx % p) / (spd + 1)];
            end
            e_tick = (t >= 1) && (t <= l) && (t <= last) && (t % (spd + 1) == 0);
            e_ld   = (t % p == 0) && (t / p < len) && (t <= last);
            e_done = (ab_at < 0) && (t == l + gap + 1);
            e_ab   = (ab_at >= 0) && (t == ab_at + 1);
            e_drop = (drop_at >= 0) && (t == drop_at + 1);
            chk("tx_out", t, tx_out, e_tx);
            chk("busy", t, busy, e_busy);
            chk("frame_done", t, frame_done, e_done);
            chk("aborted", t, aborted, e_ab);
            chk("req_dropped", t, req_dropped, e_drop);
            if (t != ab_at) begin
                chk("word_ld", t, word_ld, e_ld);
                chk("bit_tick", t, bit_tick, e_tick);
            end
        end
        send_req = 1'b0;
        abort    = 1'b0;
    endtask

    initial begin
        int spd, len, gap, l, ab, drop, lim;
        bit scr;

        rst_n      = 1'b0;
        send_req   = 1'b0;
        abort      = 1'b0;
        speedctr   = '0;
        frame_len  = '0;
        gap_cycles = '0;
        word_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst tx_out", 0, tx_out, 1'b0);
        chk("rst word_ld", 0, word_ld, 1'b0);
        chk("rst bit_tick", 0, bit_tick, 1'b0);
        chk("rst busy", 0, busy, 1'b0);
        chk("rst frame_done", 0, frame_done, 1'b0);
        chk("rst aborted", 0, aborted, 1'b0);
        chk("rst req_dropped", 0, req_dropped, 1'b0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // IDLE request handling table
        vecs[0] = '{1'b0, 1'b0, 8'd5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{1'b1, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 8'd1, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 8'd2, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            do_reset();
            @(posedge clk); #1;
            send_req   = vecs[i].send_req;
            abort      = vecs[i].abort;
            frame_len  = vecs[i].frame_len;
            speedctr   = 4'd2;
            gap_cycles = 8'd0;
            word_data  = 10'h3C5;
            @(negedge clk);
            chk("vec word_ld", i, word_ld, vecs[i].exp_ld);
            @(posedge clk); #1;
            send_req = 1'b0;
            abort    = 1'b0;
            @(negedge clk);
            chk("vec busy", i, busy, vecs[i].exp_busy);
            chk("vec req_dropped", i, req_dropped, vecs[i].exp_drop);
            chk("vec aborted", i, aborted, 1'b0);
            chk("vec tx_out", i, tx_out, vecs[i].exp_busy ? 1'b1 : 1'b0);
        end
        do_reset();

        // Basic frame
        words[0] = 10'h2AA; words[1] = 10'h155;
        run_frame(0, 2, 0, -1, -1, 1'b0);
        // Rate
        words[0] = 10'h001;
        run_frame(3, 1, 0, -1, -1, 1'b0);
        // Gap
        words[0] = 10'h0F3;
        run_frame(1, 1, 5, -1, -1, 1'b0);
        // Abort mid-frame
        for (int i = 0; i < 4; i++) words[i] = WORD_W'($urandom);
        run_frame(0, 4, 0, 15, -1, 1'b0);
        // Request while busy
        run_frame(0, 2, 2, -1, 5, 1'b0);
        // Config inputs changing mid-frame
        run_frame(0, 2, 0, -1, -1, 1'b1);
        // Longest frame length, slowest rate on a short frame
        for (int i = 0; i < 256; i++) words[i] = WORD_W'($urandom);
        run_frame(0, 255, 1, -1, -1, 1'b0);
        run_frame(15, 1, 255, -1, 200, 1'b0);

        // Reset in the middle of a frame
        @(posedge clk); #1;
        send_req = 1'b1; speedctr = 4'd0; frame_len = 8'd4; gap_cycles = 8'd3;
        word_data = 10'h3FF;
        repeat (7) begin
            @(posedge clk); #1;
            send_req = 1'b0;
        end
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int t = 0; t < 30; t++) begin
            @(negedge clk);
            chk("midrst tx_out", t, tx_out, 1'b0);
            chk("midrst busy", t, busy, 1'b0);
            chk("midrst word_ld", t, word_ld, 1'b0);
            chk("midrst bit_tick", t, bit_tick, 1'b0);
            chk("midrst frame_done", t, frame_done, 1'b0);
            chk("midrst aborted", t, aborted, 1'b0);
            chk("midrst req_dropped", t, req_dropped, 1'b0);
            @(posedge clk); #1;
        end

        // Randomized frames
        repeat (25) begin
            spd = $urandom_range(0, 15);
            len = $urandom_range(1, 4);
            gap = $urandom_range(0, 12);
            l   = len * WORD_W * (spd + 1);
            for (int i = 0; i < len; i++) words[i] = WORD_W'($urandom);
            ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, l + gap) : -1;
            lim  = (ab > 0) ? ab - 1 : l + gap;
            drop = (lim >= 1 && $urandom_range(0, 1) == 1) ? $urandom_range(1, lim) : -1;
            scr  = 1'($urandom_range(0, 1));
            run_frame(spd, len, gap, ab, drop, scr);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
